// File: rtl/mu0_regfile.sv
// mu0_regfile: DEPTH x WIDTH register bank with one write port, one increment port, two registered read ports.
// Latency 1 edge for all ports; no backpressure. Define MU0_REGFILE_BYPASS_EN for same-edge write/inc-to-read forwarding.
module mu0_regfile #(
  parameter int unsigned          WIDTH     = 12,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         inc_en,
  input  logic [$clog2(DEPTH)-1:0]     inc_addr,
  input  logic                         rd_en_a,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr_a,
  output logic [WIDTH-1:0]             qa,
  input  logic                         rd_en_b,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr_b,
  output logic [WIDTH-1:0]             qb
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] rd_val_a;
  logic [WIDTH-1:0] rd_val_b;

  // Natural WIDTH-bit wrap: all-ones + 1 becomes zero, carry is dropped.
  assign inc_val = regs[inc_addr] + WIDTH'(1);

  always_comb begin
    rd_val_a = regs[rd_addr_a];
    rd_val_b = regs[rd_addr_b];
`ifdef MU0_REGFILE_BYPASS_EN
    // Write is applied last so it overrides an increment to the same register.
    if (inc_en && (inc_addr == rd_addr_a)) rd_val_a = inc_val;
    if (wr_en  && (wr_addr  == rd_addr_a)) rd_val_a = wr_data;
    if (inc_en && (inc_addr == rd_addr_b)) rd_val_b = inc_val;
    if (wr_en  && (wr_addr  == rd_addr_b)) rd_val_b = wr_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= RESET_VAL;
      end
      qa <= '0;
      qb <= '0;
    end else begin
      // Later assignment wins: a same-address write discards the increment.
      if (inc_en) regs[inc_addr] <= inc_val;
      if (wr_en)  regs[wr_addr]  <= wr_data;
      if (rd_en_a) qa <= rd_val_a;
      if (rd_en_b) qb <= rd_val_b;
    end
  end

  logic [AW-1:0] unused_aw;
  assign unused_aw = wr_addr ^ wr_addr;

endmodule

// File: doc/mu0_regfile.md
# mu0_regfile

Parametrised multi-register bank that generalises the MU0 single 12-bit enable register (Clk, Reset, En, D, Q) into DEPTH registers of WIDTH bits. It provides one write port, one increment port for PC-style counting, and two registered read ports. It sits in the MU0 datapath in place of separate ACC/PC/IR register instances and feeds the ALU and address multiplexers.

## Interface
- WIDTH, 12, bit width of each register and of all data ports.
- DEPTH, 4, number of registers; power of two, ≥ 2. AW = log2(DEPTH) is derived locally.
- RESET_VAL, 0, value loaded into every register on reset.

- Clk  in  1  rising-edge clock. The block has one clock.
- Reset  in  1  synchronous, active-high reset, sampled on rising Clk. It has priority over all other inputs.
- WrEn  in  1  write strobe.
- WrAddr  in  AW  write register index.
- WrData  in  WIDTH  write data.
- IncEn  in  1  increment strobe.
- IncAddr  in  AW  increment register index.
- RdEnA  in  1  read port A enable.
- RdAddrA  in  AW  read port A index.
- QA  out  WIDTH  read port A data, registered.
- RdEnB  in  1  read port B enable.
- RdAddrB  in  AW  read port B index.
- QB  out  WIDTH  read port B data, registered.

## Operation
- **Reset:** all DEPTH registers load RESET_VAL. QA and QB load 0. WrEn, IncEn and RdEn are ignored in that cycle.
- **Write:** WrEn=1 sets reg[WrAddr] to WrData at the edge. Registers not addressed hold.
- **Increment:** IncEn=1 sets reg[IncAddr] to reg[IncAddr]+1, modulo 2^WIDTH. All-ones wraps to 0 with no carry output.
- **Write and increment together, same address:** the write wins and the increment is discarded.
- **Write and increment together, different addresses:** both take effect in the same edge.
- **Read:** RdEnX=1 loads QX with the selected value at the edge. RdEnX=0 holds QX at its previous value, like the MU0 En register.
- **Same address on both read ports:** legal, and both ports return identical data.
- **Read value, bypass compiled in (see Configuration):**
  - If WrEn and WrAddr==RdAddrX, QX gets WrData.
  - Otherwise, if IncEn and IncAddr==RdAddrX, QX gets reg+1 (wrapped).
  - Otherwise QX gets reg[RdAddrX].
- **Read value, bypass compiled out:** QX gets the pre-edge reg[RdAddrX].
- **Addresses:** always in range because DEPTH is a power of two. No error output exists.

## Timing
- Write/increment latency is 1 edge. The new value is visible in the register from the next cycle.
- Read latency is 1 edge: address at edge N, data on QX after edge N. This holds with or without bypass.
- Read-after-write on consecutive cycles:
  - write at edge N, read address presented for edge N+1 → QX holds the new value after N+1.
  - The bypass only affects reads sampled in the same edge as the write.
- Reset asserted mid-sequence: at that edge, pending writes, increments and reads are dropped, and all state becomes reset values. Operation resumes at the first edge with Reset=0.
- There is no combinational path from any input to QA/QB.

## Configuration
- **MU0_REGFILE_BYPASS_EN defined:** same-edge write/increment-to-read forwarding as described above. QX reflects the post-edge register contents.
- **Not defined:** no forwarding comparators are generated. QX reflects the pre-edge contents (read-before-write).

## Test plan
Defaults WIDTH=12, DEPTH=4.

- **Reset:** Reset=1 for one edge with WrEn=1, WrAddr=0, WrData=12'hABC → all registers 0, QA=QB=0. A following read of reg0 returns 0.
- **Write/read:**
  - write 12'h123 to reg2 at one edge; RdEnA=1, RdAddrA=2 at the next edge → QA=12'h123.
  - RdEnA=0 thereafter → QA holds 12'h123 while reg2 is rewritten to 12'h456.
- **Increment wrap:**
  - write 12'hFFE to reg1, then IncEn=1 on reg1 for 3 edges → reg1 sequence FFF, 000, 001.
  - QB reading reg1 every edge (bypass off) lags by one value.
- **Same-address conflict:** reg3=12'h010; WrEn and IncEn both on reg3 with WrData=12'h200 → reg3=12'h200, not 12'h011 or 12'h201.
- **Bypass:** reg0=12'h005; same edge WrEn reg0=12'h777 and RdEnA reg0, plus IncEn reg1 (=12'h0FF) and RdEnB reg1:
  - with MU0_REGFILE_BYPASS_EN → QA=12'h777, QB=12'h100.
  - without it → QA=12'h005, QB=12'h0FF.
- **Reset mid-operation:** during the running increment of reg1, assert Reset → reg1=0 and QA=QB=0 next cycle. IncEn still high after deassertion gives reg1=1 one edge later.
